// File: rtl/alarm_timer.sv
// -----------------------------------------------------------------------------
// alarm_timer
//
// Purpose: times one alarm period of DURATION ticks, where a tick is TICK_DIV
// clk cycles. While running, the LED selected by the latched alarm code blinks
// with a 50% duty cycle per tick, and the buzzer pulses in phase with it.
// When the period has elapsed the block holds done high until it is cleared.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   en         in   count enable (low = pause while running)
//   r_setn     in   synchronous active-low clear; overrides everything else
//   code_sel   in   [1:0] alarm code; latched only on IDLE->RUN entry
//   done       out  alarm period complete (level, DONE state)
//   led        out  [3:0] one-hot blink output for the latched code
//   buzzer     out  audible pulse, same phase as the active led
//   remaining  out  [7:0] ticks left in the current alarm
//   dbg_state  out  [1:0] FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
// Control semantics: en and r_setn are level controls sampled on every rising
// edge. r_setn=0 wins over en and over a tick landing on the same edge.
// There is no valid/ready handshake on this block.
// -----------------------------------------------------------------------------
module alarm_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int DURATION = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       r_setn,
  input  logic [1:0] code_sel,
  output logic       done,
  output logic [3:0] led,
  output logic       buzzer,
  output logic [7:0] remaining,
  output logic [1:0] dbg_state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [7:0] DUR = 8'(DURATION);
  localparam logic [7:0] DUR_LAST = 8'(DURATION - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    elapsed_q, elapsed_d;
  logic [1:0]    code_q, code_d;
  logic          phase_q, phase_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      elapsed_q <= '0;
      code_q    <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      code_q    <= code_d;
      phase_q   <= phase_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    elapsed_d = elapsed_q;
    code_d    = code_q;

    if (!r_setn) begin
      state_d   = S_IDLE;
      presc_d   = '0;
      elapsed_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          presc_d   = '0;
          elapsed_d = '0;
          if (en) begin
            state_d = S_RUN;
            code_d  = code_sel;
          end
        end
        S_RUN: begin
          // en=0 leaves every counter untouched (pause)
          if (en) begin
            if (presc_q == PRESC_MAX) begin
              presc_d = '0;
              if (elapsed_q == DUR_LAST) begin
                state_d   = S_DONE;
                elapsed_d = DUR;
              end else begin
                elapsed_d = elapsed_q + 8'd1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        S_DONE: begin
          // frozen until r_setn=0
        end
        default: begin
          state_d   = S_IDLE;
          presc_d   = '0;
          elapsed_d = '0;
        end
      endcase
    end

    // Phase is stored so the blink outputs come straight from a flop;
    // it is the first half of each tick, and zero whenever not running.
    phase_d = (state_d == S_RUN) && (presc_d < PRESC_HALF);
  end

  // Output decode from registered state only
  always_comb begin
    done      = 1'b0;
    led       = 4'b0000;
    buzzer    = phase_q;
    remaining = DUR;
    dbg_state = state_q;
    unique case (state_q)
      S_IDLE: remaining = DUR;
      S_RUN: begin
        remaining    = DUR - elapsed_q;
        led[code_q]  = phase_q;
      end
      S_DONE: begin
        done      = 1'b1;
        remaining = 8'd0;
      end
      default: remaining = DUR;
    endcase
  end

endmodule
